// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the LFSR-driven pattern detector, plus the
// elaboration-time builder for the overlapping-match transition table.
package pattern_det_pkg;

  localparam int               LFSR_W          = 16;
  localparam logic [LFSR_W-1:0] TAP_MASK       = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED   = 16'hACE1;
  localparam int               PAT_W           = 4;
  localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1011;
  localparam int               COUNT_W         = 8;
  localparam int               TBL_W           = 48;

  // State value == length of the longest pattern prefix matched so far.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G1   = 3'd1,
    G2   = 3'd2,
    G3   = 3'd3,
    HIT  = 3'd4
  } state_e;

  // Indexed by {state, incoming bit}; unused state codes fall back to IDLE.
  typedef logic [15:0][2:0] next_tbl_t;

  // For every (matched length, bit) pair, the new length is the longest
  // pattern prefix that is a suffix of the history, i.e. the KMP automaton.
  function automatic next_tbl_t build_next_tbl(input logic [PAT_W-1:0] pat);
    logic [TBL_W-1:0] flat;
    int p;
    int h;
    int n;
    int best;
    flat = '0;
    p    = 32'(pat);
    for (int l = 0; l <= PAT_W; l++) begin
      for (int b = 0; b < 2; b++) begin
        h    = ((p >> (PAT_W - l)) << 1) | b;
        n    = l + 1;
        best = 0;
        for (int k = 1; k <= PAT_W; k++) begin
          if (k <= n && ((h & ((1 << k) - 1)) == (p >> (PAT_W - k)))) begin
            best = k;
          end
        end
        flat = flat | (TBL_W'(best) << (3 * (2 * l + b)));
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advancing every cycle.
// wrap flags that the state about to be loaded is the seed again.
module lfsr16
  import pattern_det_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q,
  output logic              msb,
  output logic              wrap
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  always_comb begin
    fb     = ^(lfsr_q & TAP_MASK);
    lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
  end

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of the order in which processes are evaluated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q    = lfsr_q;
  assign msb  = lfsr_q[LFSR_W-1];
  assign wrap = (lfsr_d == SEED);

endmodule

// File: rtl/lfsr_pattern_det.sv
// Self-stimulating detector: an LFSR bit stream feeds a Moore matcher for
// PATTERN (overlap allowed) and a saturating per-period hit counter.
module lfsr_pattern_det
  import pattern_det_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED,
  parameter logic [PAT_W-1:0]  PATTERN = DEFAULT_PATTERN
) (
  input  logic               clk,
  input  logic               reset,
  output logic               max_tick_reg,
  output logic [COUNT_W-1:0] count,
  output logic               pattern,
  output logic               lfsr_msb,
  output logic [LFSR_W-1:0]  lfsr_reg
);

  localparam next_tbl_t          NEXT_TBL  = build_next_tbl(PATTERN);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [LFSR_W-1:0]  lfsr_w;
  logic               msb_w;
  logic               wrap_w;
  logic               serial_bit;

  state_e             state_q;
  state_e             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               tick_q;
  logic               tick_d;
  logic               hit_d;
  logic [3:0]         tbl_idx;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_w),
    .msb  (msb_w),
    .wrap (wrap_w)
  );

  assign serial_bit = msb_w;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tbl_idx = {state_q, serial_bit};
    state_d = state_e'(NEXT_TBL[tbl_idx]);
    hit_d   = (state_d == HIT);
    tick_d  = wrap_w;
    count_d = count_q;
    // A wrap starts a new period; a hit on that same edge belongs to it.
    if (wrap_w) begin
      count_d = hit_d ? COUNT_W'(1) : '0;
    end else if (hit_d && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign pattern      = (state_q == HIT);
  assign count        = count_q;
  assign max_tick_reg = tick_q;
  assign lfsr_msb     = serial_bit;
  assign lfsr_reg     = lfsr_w;

endmodule

// File: tb/tb_lfsr_pattern_det.sv
// Directed and scoreboard checks for lfsr_pattern_det: reset, first cycles,
// async reset, forced overlapping stream, and one full LFSR period.
module tb_lfsr_pattern_det;

  logic        clk;
  logic        reset;
  logic        max_tick_reg;
  logic [7:0]  count;
  logic        pattern;
  logic        lfsr_msb;
  logic [15:0] lfsr_reg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lfsr_pattern_det dut (
    .clk         (clk),
    .reset       (reset),
    .max_tick_reg(max_tick_reg),
    .count       (count),
    .pattern     (pattern),
    .lfsr_msb    (lfsr_msb),
    .lfsr_reg    (lfsr_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       msb;
    logic       pat;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Leaves the bench at a negedge with reset just released (cycle 0).
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lfsr"},  32'(lfsr_reg), 32'h0000ACE1);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_pat"},   32'(pattern), 0);
    check({tag, "_tick"},  32'(max_tick_reg), 0);
  endtask

  function automatic int ref_next(input int s, input logic b);
    case (s)
      0:       return b ? 1 : 0;
      1:       return b ? 1 : 2;
      2:       return b ? 3 : 0;
      3:       return b ? 4 : 2;
      4:       return b ? 1 : 2;
      default: return 0;
    endcase
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] msb_bits;
    logic [6:0]  fseq;
    logic [15:0] m_lfsr;
    logic [15:0] m_next;
    int          m_state;
    int          m_hits;
    logic [7:0]  m_cnt;
    logic        m_tick;
    logic        m_wrap;
    int          err_lfsr, err_msb, err_pat, err_cnt, err_tick;
    int          tick_n, first_tick;
    logic [15:0] tick_lfsr;
    logic [7:0]  cnt_pre, mcnt_pre, cnt_post, mcnt_post;

    msb_bits = 16'b1010_1100_1110_0001;
    for (int c = 0; c < 17; c++) begin
      vecs[c].msb = (c < 16) ? msb_bits[4'(15 - c)] : 1'b1;
      vecs[c].pat = (c == 6);
      vecs[c].cnt = (c >= 6) ? 8'd1 : 8'd0;
    end

    // Reset held, then released.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    for (int c = 0; c < 17; c++) begin
      check($sformatf("msb_c%0d", c), 32'(lfsr_msb), 32'(vecs[c].msb));
      check($sformatf("pat_c%0d", c), 32'(pattern), 32'(vecs[c].pat));
      check($sformatf("cnt_c%0d", c), 32'(count), 32'(vecs[c].cnt));
      check($sformatf("tick_c%0d", c), 32'(max_tick_reg), 0);
      if (c == 0) check("lfsr_c0", 32'(lfsr_reg), 32'h0000ACE1);
      if (c == 1) check("lfsr_c1", 32'(lfsr_reg), 32'h000059C3);
      @(negedge clk);
    end

    // Asynchronous reset between edges.
    do_reset();
    repeat (7) @(negedge clk);
    check("pre_arst_count", 32'(count), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    reset = 1'b1;

    // Forced stream 1,0,1,1,0,1,1: overlapping hits in cycles 4 and 7.
    do_reset();
    fseq = 7'b1011011;
    for (int j = 0; j < 7; j++) begin
      if (fseq[3'(6 - j)]) force dut.serial_bit = 1'b1;
      else                 force dut.serial_bit = 1'b0;
      @(negedge clk);
      check($sformatf("ovl_pat_c%0d", j + 1), 32'(pattern),
            32'((j + 1 == 4) || (j + 1 == 7)));
    end
    check("ovl_count", 32'(count), 2);
    release dut.serial_bit;

    // Scoreboard over one full period and a few cycles past the wrap.
    do_reset();
    m_lfsr = 16'hACE1; m_state = 0; m_hits = 0; m_cnt = 8'd0; m_tick = 1'b0;
    err_lfsr = 0; err_msb = 0; err_pat = 0; err_cnt = 0; err_tick = 0;
    tick_n = 0; first_tick = -1; tick_lfsr = '0;
    cnt_pre = '0; mcnt_pre = '0; cnt_post = '0; mcnt_post = '0;
    for (int c = 0; c <= 65540; c++) begin
      if (lfsr_reg !== m_lfsr)          err_lfsr++;
      if (lfsr_msb !== m_lfsr[15])      err_msb++;
      if (pattern !== (m_state == 4))   err_pat++;
      if (count !== m_cnt)              err_cnt++;
      if (max_tick_reg !== m_tick)      err_tick++;
      if (max_tick_reg === 1'b1) begin
        tick_n++;
        if (tick_n == 1) begin
          first_tick = c;
          tick_lfsr  = lfsr_reg;
        end
      end
      if (c == 65534) begin cnt_pre = count;  mcnt_pre = m_cnt;  end
      if (c == 65535) begin cnt_post = count; mcnt_post = m_cnt; end

      m_next  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_state = ref_next(m_state, m_lfsr[15]);
      m_wrap  = (m_next == 16'hACE1);
      if (m_wrap)            m_hits = (m_state == 4) ? 1 : 0;
      else if (m_state == 4) m_hits++;
      m_cnt  = (m_hits > 255) ? 8'd255 : 8'(m_hits);
      m_tick = m_wrap;
      m_lfsr = m_next;
      @(negedge clk);
    end
    check("sb_lfsr_mismatches",  32'(err_lfsr), 0);
    check("sb_msb_mismatches",   32'(err_msb), 0);
    check("sb_pat_mismatches",   32'(err_pat), 0);
    check("sb_count_mismatches", 32'(err_cnt), 0);
    check("sb_tick_mismatches",  32'(err_tick), 0);
    check("wrap_tick_count",     32'(tick_n), 1);
    check("wrap_tick_cycle",     32'(first_tick), 65535);
    check("wrap_tick_lfsr",      32'(tick_lfsr), 32'h0000ACE1);
    check("sat_count_pre_wrap",  32'(cnt_pre), 32'(mcnt_pre));
    check("sat_count_is_max",    32'(cnt_pre), 255);
    check("count_post_wrap",     32'(cnt_post), 32'(mcnt_post));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
